// File: rtl/jtframe_bank_rr_pkg.sv
// Shared types for the round-robin SDRAM bank arbiter.
// Holds the arbiter state encoding and the pointer-width helper.
package jtframe_bank_rr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // A single requester still needs one bit so the pointer is never zero-width
  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jtframe_bank_rr_pick.sv
// Rotating priority encoder: first asserted request at or after ptr, with wrap-around.
// Purely combinational; the arbiter registers its result.
module jtframe_bank_rr_pick
  import jtframe_bank_rr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]           req,
  input  logic [ptr_w(N)-1:0]    ptr,
  output logic                   valid,
  output logic [ptr_w(N)-1:0]    idx
);

  localparam int PW = ptr_w(N);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!valid && req[PW'(j)]) begin
        valid = 1'b1;
        idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/jtframe_bank_rr.sv
// Round-robin arbiter sharing one SDRAM bank port among N requesters.
// Latches the winner's command until the bank accepts and routes completion strobes to it.
module jtframe_bank_rr
  import jtframe_bank_rr_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = 22,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    we,
  input  logic [N*AW-1:0] addr,
  input  logic [N*DW-1:0] din,
  input  logic [N*2-1:0]  dsn,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    dst,
  output logic [N-1:0]    dok,
  output logic [N-1:0]    rdy,
  output logic [DW-1:0]   dout,
  output logic [AW-1:0]   ba_addr,
  output logic            ba_rd,
  output logic            ba_wr,
  output logic [DW-1:0]   ba_din,
  output logic [1:0]      ba_dsn,
  input  logic            ba_ack,
  input  logic            ba_dst,
  input  logic            ba_dok,
  input  logic            ba_rdy,
  input  logic [DW-1:0]   sdram_dout
);

  localparam int PW = ptr_w(N);

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic [1:0]      dsn_q, dsn_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            ba_rd_q, ba_rd_d;
  logic            ba_wr_q, ba_wr_d;

  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic [N-1:0]    owner_oh;
  logic            own_req;

  jtframe_bank_rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_oh = N'(1) << owner_q;
  assign own_req  = req[owner_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dsn_d   = dsn_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    ba_rd_d = ba_rd_q;
    ba_wr_d = ba_wr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          we_d    = we[pick_idx];
          addr_d  = addr[int'(pick_idx)*AW +: AW];
          din_d   = din[int'(pick_idx)*DW +: DW];
          dsn_d   = dsn[int'(pick_idx)*2 +: 2];
          gnt_d   = N'(1) << pick_idx;
          ba_rd_d = ~we[pick_idx];
          ba_wr_d = we[pick_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // An acceptance outranks a simultaneous request drop
        if (ba_ack) begin
          ack_d   = owner_oh;
          ba_rd_d = 1'b0;
          ba_wr_d = 1'b0;
          state_d = WAIT;
        end else if (!own_req) begin
          ba_rd_d = 1'b0;
          ba_wr_d = 1'b0;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (ba_rdy) begin
          ptr_d   = (owner_q == PW'(N-1)) ? '0 : owner_q + PW'(1);
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      dsn_q   <= 2'b11;
      gnt_q   <= '0;
      ack_q   <= '0;
      ba_rd_q <= 1'b0;
      ba_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dsn_q   <= dsn_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      ba_rd_q <= ba_rd_d;
      ba_wr_q <= ba_wr_d;
    end
  end

  // Completion strobes reach only the owner, and only once the bank has accepted
  assign dst = (state_q == WAIT && ba_dst) ? owner_oh : '0;
  assign dok = (state_q == WAIT && ba_dok) ? owner_oh : '0;
  assign rdy = (state_q == WAIT && ba_rdy) ? owner_oh : '0;

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign dout    = sdram_dout;
  assign ba_addr = addr_q;
  assign ba_din  = din_q;
  assign ba_dsn  = dsn_q;
  assign ba_rd   = ba_rd_q;
  assign ba_wr   = ba_wr_q;

endmodule

// File: tb/tb_jtframe_bank_rr.sv
// Scoreboard bench for jtframe_bank_rr: a behavioural round-robin model predicts each
// grant, and a negedge monitor checks commands, acks and routed strobes as they appear.
module tb_jtframe_bank_rr;

  localparam int N  = 4;
  localparam int AW = 22;
  localparam int DW = 16;

  typedef struct {
    int              owner;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   din;
    logic [1:0]      dsn;
    logic            completes;
  } txn_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] din;
  logic [N*2-1:0]  dsn;
  logic [N-1:0]    gnt, ack, dst, dok, rdy;
  logic [DW-1:0]   dout;
  logic [AW-1:0]   ba_addr;
  logic            ba_rd, ba_wr;
  logic [DW-1:0]   ba_din;
  logic [1:0]      ba_dsn;
  logic            ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [DW-1:0]   sdram_dout;

  int              n_cmp  = 0;
  int              n_fail = 0;
  int              ptr_m  = 0;
  txn_t            exp_q[$];
  logic [3*N-1:0]  strobe_q[$];
  int              grant_log[$];
  txn_t            cur;
  bit              in_txn   = 0;
  bit              seen_ack = 0;

  jtframe_bank_rr #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .din        (din),
    .dsn        (dsn),
    .gnt        (gnt),
    .ack        (ack),
    .dst        (dst),
    .dok        (dok),
    .rdy        (rdy),
    .dout       (dout),
    .ba_addr    (ba_addr),
    .ba_rd      (ba_rd),
    .ba_wr      (ba_wr),
    .ba_din     (ba_din),
    .ba_dsn     (ba_dsn),
    .ba_ack     (ba_ack),
    .ba_dst     (ba_dst),
    .ba_dok     (ba_dok),
    .ba_rdy     (ba_rdy),
    .sdram_dout (sdram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int o);
    logic [N-1:0] v;
    v = '0;
    v[o] = 1'b1;
    return v;
  endfunction

  // Reference arbitration rule: first requester at or after ptr, wrapping modulo N
  function automatic int pick_model(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randFields();
    for (int i = 0; i < N; i++) begin
      we[i]             = 1'($urandom);
      addr[i*AW +: AW]  = AW'($urandom);
      din[i*DW +: DW]   = DW'($urandom);
      dsn[i*2 +: 2]     = 2'($urandom);
    end
  endtask

  task automatic strayStrobes();
    ba_dst     = 1'($urandom);
    ba_dok     = 1'($urandom);
    ba_rdy     = 1'($urandom);
    sdram_dout = DW'($urandom);
  endtask

  task automatic clearStrobes();
    ba_dst = 1'b0;
    ba_dok = 1'b0;
    ba_rdy = 1'b0;
  endtask

  task automatic driveStrobes(input int o, input bit s, input bit k, input bit y);
    ba_dst     = s;
    ba_dok     = k;
    ba_rdy     = y;
    sdram_dout = DW'($urandom);
    if (s || k || y)
      strobe_q.push_back({s ? onehot(o) : N'(0), k ? onehot(o) : N'(0), y ? onehot(o) : N'(0)});
  endtask

  // One arbitration round starting in IDLE; abort_at < 0 means the request completes
  task automatic applyStimulus(input logic [N-1:0] r, input int abort_at, input int ack_lat,
                               input int wait_lat, input bit drop_on_ack);
    txn_t t;
    int   o;
    o           = pick_model(r, ptr_m);
    t.owner     = o;
    t.we        = we[o];
    t.addr      = addr[o*AW +: AW];
    t.din       = din[o*DW +: DW];
    t.dsn       = dsn[o*2 +: 2];
    t.completes = (abort_at < 0);
    exp_q.push_back(t);
    req = r;
    strayStrobes();
    tick();
    clearStrobes();
    checkOutput("grant_latency", 64'(gnt), 64'(onehot(o)));
    if (abort_at >= 0) begin
      repeat (abort_at) begin
        randFields();
        strayStrobes();
        tick();
      end
      req[o] = 1'b0;
      strayStrobes();
      tick();
      clearStrobes();
      checkOutput("abort_gnt", 64'(gnt), 64'd0);
      checkOutput("abort_cmd", 64'({ba_rd, ba_wr}), 64'd0);
      req = '0;
    end else begin
      repeat (ack_lat) begin
        randFields();
        strayStrobes();
        tick();
      end
      clearStrobes();
      ba_ack = 1'b1;
      if (drop_on_ack) req[o] = 1'b0;
      tick();
      ba_ack = 1'b0;
      repeat (wait_lat) begin
        driveStrobes(o, 1'($urandom), 1'($urandom), 1'b0);
        if ($urandom_range(0, 1) == 0) req = '0;
        tick();
      end
      driveStrobes(o, 1'($urandom), 1'($urandom), 1'b1);
      tick();
      clearStrobes();
      req   = '0;
      ptr_m = (o + 1) % N;
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_txn   = 0;
        seen_ack = 0;
      end else begin
        if (!in_txn && gnt != '0) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_grant", 64'(gnt), 64'd0);
          end else begin
            cur = exp_q.pop_front();
            checkOutput("grant_owner", 64'(gnt), 64'(onehot(cur.owner)));
            in_txn   = 1;
            seen_ack = 0;
            for (int i = 0; i < N; i++) if (gnt[i]) grant_log.push_back(i);
          end
        end
        if (in_txn && (ba_rd || ba_wr)) begin
          checkOutput("cmd_dir", 64'({ba_rd, ba_wr}), 64'({~cur.we, cur.we}));
          checkOutput("ba_addr", 64'(ba_addr), 64'(cur.addr));
          checkOutput("ba_din", 64'(ba_din), 64'(cur.din));
          checkOutput("ba_dsn", 64'(ba_dsn), 64'(cur.dsn));
        end
        if (ack != '0) begin
          checkOutput("ack_owner", 64'(ack), in_txn ? 64'(onehot(cur.owner)) : 64'd0);
          checkOutput("ack_single", 64'(seen_ack), 64'd0);
          checkOutput("cmd_after_ack", 64'({ba_rd, ba_wr}), 64'd0);
          seen_ack = 1;
        end
        if (in_txn && gnt == '0) begin
          checkOutput("txn_outcome", 64'(seen_ack), 64'(cur.completes));
          in_txn = 0;
        end
        if ({dst, dok, rdy} != '0) begin
          if (strobe_q.size() == 0)
            checkOutput("stray_strobe", 64'({dst, dok, rdy}), 64'd0);
          else
            checkOutput("strobe_route", 64'({dst, dok, rdy}), 64'(strobe_q.pop_front()));
          if (dok != '0) checkOutput("dout", 64'(dout), 64'(sdram_dout));
        end
      end
    end
  end

  initial begin : stimulus
    int order[5];
    txn_t t;
    order      = '{0, 1, 2, 3, 0};
    rst_n      = 1'b1;
    req        = '0;
    we         = '0;
    addr       = '0;
    din        = '0;
    dsn        = '1;
    ba_ack     = 1'b0;
    sdram_dout = '0;
    clearStrobes();
    #2 rst_n = 1'b0;
    #2;
    checkOutput("reset_gnt", 64'(gnt), 64'd0);
    checkOutput("reset_cmd", 64'({ba_rd, ba_wr}), 64'd0);
    checkOutput("reset_ack", 64'(ack), 64'd0);
    checkOutput("reset_dsn", 64'(ba_dsn), 64'd3);
    checkOutput("reset_addr", 64'(ba_addr), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Contention with every requester asking
    for (int i = 0; i < 5; i++) begin
      randFields();
      applyStimulus(4'b1111, -1, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end
    checkOutput("rr_log_len", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      checkOutput("rr_order", 64'(grant_log[i]), 64'(order[i]));

    randFields();
    we[2] = 1'b0;
    addr[2*AW +: AW] = 22'h12345;
    applyStimulus(4'b0100, -1, 1, 2, 1'b0);

    randFields();
    we[1] = 1'b1;
    din[1*DW +: DW] = 16'hBEEF;
    dsn[1*2 +: 2] = 2'b10;
    applyStimulus(4'b0010, -1, 3, 1, 1'b0);

    randFields();
    applyStimulus(4'b1000, 2, 0, 0, 1'b0);
    randFields();
    applyStimulus(4'b1111, -1, 0, 1, 1'b0);
    randFields();
    applyStimulus(4'b1000, -1, 1, 1, 1'b1);

    req = '0;
    ba_dst = 1'b1;
    ba_dok = 1'b1;
    ba_rdy = 1'b1;
    #1;
    checkOutput("stray_idle", 64'({dst, dok, rdy}), 64'd0);
    tick();
    clearStrobes();

    for (int i = 0; i < 80; i++) begin
      randFields();
      applyStimulus(N'($urandom_range(1, (1 << N) - 1)),
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1,
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3) == 0);
    end

    // Async reset while the bank is mid-transaction
    randFields();
    applyStimulus(4'b0010, -1, 0, 0, 1'b0);
    randFields();
    t.owner = pick_model(4'b0100, ptr_m);
    t.we = we[t.owner];
    t.addr = addr[t.owner*AW +: AW];
    t.din = din[t.owner*DW +: DW];
    t.dsn = dsn[t.owner*2 +: 2];
    t.completes = 1'b1;
    exp_q.push_back(t);
    req = 4'b0100;
    tick();
    ba_ack = 1'b1;
    tick();
    ba_ack = 1'b0;
    driveStrobes(t.owner, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_wait_gnt", 64'(gnt), 64'd0);
    checkOutput("rst_wait_cmd", 64'({ba_rd, ba_wr, ack}), 64'd0);
    checkOutput("rst_wait_dok", 64'(dok), 64'd0);
    checkOutput("rst_wait_dsn", 64'(ba_dsn), 64'd3);
    checkOutput("rst_wait_addr", 64'(ba_addr), 64'd0);
    clearStrobes();
    req = '0;
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    ptr_m = 0;
    randFields();
    applyStimulus(4'b1001, -1, 1, 1, 1'b0);

    repeat (3) tick();
    checkOutput("pending_txn", 64'(exp_q.size()), 64'd0);
    checkOutput("pending_strobes", 64'(strobe_q.size()), 64'd0);
    checkOutput("open_txn", 64'(in_txn), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
